game_ctrl: RTL and testbench

//  Turn scheduler and referee for the 3x3 board store. Arbitrates moves between the

---
 rtl/game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Turn scheduler and referee for a 3x3 board: arbitrates player/cpu moves, validates,
// writes, and scans for win/draw. Optional turn timeout under GAME_CTRL_TIMEOUT_EN.
module game_ctrl #(
   parameter int unsigned CELL_W     = 2,
   parameter bit          FIRST_TURN = 1'b0
`ifdef GAME_CTRL_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  p_valid,
   output logic                  p_ready,
   input  logic [3:0]            p_loc,
   input  logic                  c_valid,
   output logic                  c_ready,
   input  logic [3:0]            c_loc,
   input  logic [9*CELL_W-1:0]   board,
   output logic                  board_we,
   output logic [3:0]            board_loc,
   output logic [CELL_W-1:0]     board_val,
   output logic                  board_clr,
   output logic                  turn,
   output logic                  move_err,
   output logic                  timeout,
   output logic                  game_over,
   output logic [1:0]            winner,
   output logic [3:0]            move_cnt
);

   typedef enum logic [2:0] {
      StIdle, StClear, StWaitMove, StCheck, StWrite, StScan, StDone
   } state_e;

   state_e            state;
   logic [3:0]        loc;
   logic [2:0]        line;
   logic [CELL_W-1:0] cells [9];
   logic [3:0]        ia, ib, ic;
   logic [CELL_W-1:0] ca, cb, cc;
   logic              line_win;
   logic              illegal;
   logic              accept;
   logic              expire;

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         cells[i] = board[i*CELL_W +: CELL_W];
      end
   end

   // Scan order: rows, columns, main diagonal, anti-diagonal.
   always_comb begin
      {ia, ib, ic} = {4'd0, 4'd1, 4'd2};
      unique case (line)
         3'd0: {ia, ib, ic} = {4'd0, 4'd1, 4'd2};
         3'd1: {ia, ib, ic} = {4'd3, 4'd4, 4'd5};
         3'd2: {ia, ib, ic} = {4'd6, 4'd7, 4'd8};
         3'd3: {ia, ib, ic} = {4'd0, 4'd3, 4'd6};
         3'd4: {ia, ib, ic} = {4'd1, 4'd4, 4'd7};
         3'd5: {ia, ib, ic} = {4'd2, 4'd5, 4'd8};
         3'd6: {ia, ib, ic} = {4'd0, 4'd4, 4'd8};
         3'd7: {ia, ib, ic} = {4'd2, 4'd4, 4'd6};
      endcase
   end

   assign ca       = cells[ia];
   assign cb       = cells[ib];
   assign cc       = cells[ic];
   assign line_win = (ca != '0) && (ca == cb) && (cb == cc);
   assign illegal  = (loc > 4'd8) ? 1'b1 : (cells[loc] != '0);
   assign accept   = turn ? (c_valid && c_ready) : (p_valid && p_ready);

`ifdef GAME_CTRL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   // Zero on every entry to WAIT_MOVE because it is held clear in all other states.
   always_ff @(posedge clk) begin
      if (reset || state != StWaitMove || expire) idle_cnt <= '0;
      else                                        idle_cnt <= idle_cnt + TW'(1);
   end

   assign expire = (state == StWaitMove) && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         loc       <= '0;
         line      <= '0;
         p_ready   <= 1'b0;
         c_ready   <= 1'b0;
         turn      <= FIRST_TURN;
         board_we  <= 1'b0;
         board_loc <= '0;
         board_val <= '0;
         board_clr <= 1'b0;
         move_err  <= 1'b0;
         timeout   <= 1'b0;
         game_over <= 1'b0;
         winner    <= '0;
         move_cnt  <= '0;
      end else begin
         board_we  <= 1'b0;
         board_clr <= 1'b0;
         move_err  <= 1'b0;
         timeout   <= 1'b0;
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state     <= StClear;
                  board_clr <= 1'b1;
                  move_cnt  <= '0;
                  turn      <= FIRST_TURN;
                  game_over <= 1'b0;
                  winner    <= '0;
               end
            end
            StClear: begin
               state   <= StWaitMove;
               p_ready <= !turn;
               c_ready <= turn;
            end
            StWaitMove: begin
               if (accept) begin
                  loc     <= turn ? c_loc : p_loc;
                  p_ready <= 1'b0;
                  c_ready <= 1'b0;
                  state   <= StCheck;
               end else if (expire) begin
                  timeout <= 1'b1;
                  turn    <= !turn;
                  p_ready <= turn;
                  c_ready <= !turn;
               end
            end
            StCheck: begin
               if (illegal) begin
                  move_err <= 1'b1;
                  p_ready  <= !turn;
                  c_ready  <= turn;
                  state    <= StWaitMove;
               end else begin
                  board_we  <= 1'b1;
                  board_loc <= loc;
                  board_val <= turn ? CELL_W'(2) : CELL_W'(1);
                  move_cnt  <= move_cnt + 4'd1;
                  state     <= StWrite;
               end
            end
            StWrite: begin
               line  <= '0;
               state <= StScan;
            end
            StScan: begin
               if (line_win) begin
                  state     <= StDone;
                  game_over <= 1'b1;
                  winner    <= 2'(ca);
               end else if (line == 3'd7) begin
                  if (move_cnt == 4'd9) begin
                     state     <= StDone;
                     game_over <= 1'b1;
                     winner    <= 2'd0;
                  end else begin
                     turn    <= !turn;
                     p_ready <= turn;
                     c_ready <= !turn;
                     state   <= StWaitMove;
                  end
               end else begin
                  line <= line + 3'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: board store model, event-schedule reference model,
// per-cycle compare process and directed game scenarios.
module tb_game_ctrl;

   localparam int unsigned CW = 2;
`ifdef GAME_CTRL_TIMEOUT_EN
   localparam int TO = 16;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            p_valid = 1'b0;
   logic            c_valid = 1'b0;
   logic [3:0]      p_loc = '0;
   logic [3:0]      c_loc = '0;
   logic            p_ready, c_ready, board_we, board_clr, turn, move_err, timeout, game_over;
   logic [3:0]      board_loc, move_cnt;
   logic [CW-1:0]   board_val;
   logic [1:0]      winner;
   logic [9*CW-1:0] board;
   logic            tb_clr = 1'b1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   game_ctrl #(
      .CELL_W(CW),
      .FIRST_TURN(1'b0)
`ifdef GAME_CTRL_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .p_valid(p_valid), .p_ready(p_ready), .p_loc(p_loc),
      .c_valid(c_valid), .c_ready(c_ready), .c_loc(c_loc),
      .board(board), .board_we(board_we), .board_loc(board_loc), .board_val(board_val),
      .board_clr(board_clr), .turn(turn), .move_err(move_err), .timeout(timeout),
      .game_over(game_over), .winner(winner), .move_cnt(move_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Board store: registers writes, cleared by board_clr (not by reset).
   logic [CW-1:0] store [9];
   always @(posedge clk) begin
      if (board_clr || tb_clr) begin
         for (int i = 0; i < 9; i++) store[i] <= '0;
      end else if (board_we && board_loc < 4'd9) begin
         store[board_loc] <= board_val;
      end
   end
   always_comb begin
      board = '0;
      for (int i = 0; i < 9; i++) board[i*CW +: CW] = store[i];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s at cycle %0d: bounded wait expired", name, cyc);
   endtask

   // ---------------- reference model: schedules output events per accepted move
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int m_board [9];
   int e_wait, e_turn, e_cnt, e_over, e_win, e_idle, armed = 0;
   int clr_at, we_at, we_loc, we_val, err_at, to_at, tog_at;
   int wait_at, w_turn, cnt_at, cnt_val, done_at, done_win;
   int mc, m_acc, m_loc, m_k;
`ifdef GAME_CTRL_TIMEOUT_EN
   int w_cnt;
`endif

   function automatic int first_win();
      for (int i = 0; i < 8; i++) begin
         if (m_board[lines[i][0]] != 0 && m_board[lines[i][0]] == m_board[lines[i][1]] &&
             m_board[lines[i][1]] == m_board[lines[i][2]]) return i;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      mc = cyc;
      if (reset) begin
         armed = 1;
         e_wait = 0; e_turn = 0; e_cnt = 0; e_over = 0; e_win = 0; e_idle = 1;
         clr_at = -1; we_at = -1; err_at = -1; to_at = -1; tog_at = -1;
         wait_at = -1; cnt_at = -1; done_at = -1;
      end else if (armed != 0) begin
         if (mc == clr_at) begin
            e_cnt = 0; e_win = 0; e_over = 0; e_turn = 0;
            for (int i = 0; i < 9; i++) m_board[i] = 0;
         end
         if (mc == wait_at) begin
            e_wait = 1;
            e_turn = w_turn;
`ifdef GAME_CTRL_TIMEOUT_EN
            w_cnt = 0;
`endif
         end
         if (mc == cnt_at) e_cnt = cnt_val;
         if (mc == done_at) begin e_over = 1; e_win = done_win; e_idle = 1; end
         if (mc == tog_at) e_turn = 1 - e_turn;

         chk("p_ready", p_ready, (e_wait != 0 && e_turn == 0) ? 1 : 0);
         chk("c_ready", c_ready, (e_wait != 0 && e_turn == 1) ? 1 : 0);
         chk("turn", turn, e_turn);
         chk("board_clr", board_clr, (mc == clr_at) ? 1 : 0);
         chk("board_we", board_we, (mc == we_at) ? 1 : 0);
         if (mc == we_at) begin
            chk("board_loc", board_loc, we_loc);
            chk("board_val", board_val, we_val);
         end
         chk("move_err", move_err, (mc == err_at) ? 1 : 0);
         chk("timeout", timeout, (mc == to_at) ? 1 : 0);
         chk("game_over", game_over, e_over);
         chk("winner", winner, e_win);
         chk("move_cnt", move_cnt, e_cnt);

         if (e_idle != 0 && start) begin
            e_idle = 0; clr_at = mc + 1; wait_at = mc + 2; w_turn = 0;
         end else if (e_wait != 0) begin
            m_acc = (e_turn == 1) ? int'(c_valid) : int'(p_valid);
            m_loc = (e_turn == 1) ? int'(c_loc) : int'(p_loc);
            if (m_acc != 0) begin
               e_wait = 0;
               if (m_loc > 8 || m_board[m_loc] != 0) begin
                  err_at = mc + 2; wait_at = mc + 2; w_turn = e_turn;
               end else begin
                  m_board[m_loc] = e_turn + 1;
                  we_at = mc + 2; we_loc = m_loc; we_val = e_turn + 1;
                  cnt_at = mc + 2; cnt_val = e_cnt + 1;
                  m_k = first_win();
                  if (m_k >= 0) begin
                     done_at = mc + 4 + m_k; done_win = e_turn + 1;
                  end else if (cnt_val == 9) begin
                     done_at = mc + 11; done_win = 0;
                  end else begin
                     wait_at = mc + 11; w_turn = 1 - e_turn;
                  end
               end
            end
`ifdef GAME_CTRL_TIMEOUT_EN
            else begin
               w_cnt++;
               if (w_cnt == TO) begin to_at = mc + 1; tog_at = mc + 1; w_cnt = 0; end
            end
`endif
         end
      end
   end

   // ---------------- stimulus with hand-computed literal expectations
   function automatic logic sig(input int w);
      case (w)
         0:       return board_we;
         1:       return c_ready;
         2:       return p_ready;
         3:       return game_over;
         4:       return move_err;
         default: return timeout;
      endcase
   endfunction

   task automatic wait_sig(input int w, input string name, output int at);
      int n = 0;
      while (sig(w) !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) fail(name);
      at = cyc;
   endtask

   // Drives the active side's move; the idle side raises valid too and must be ignored.
   task automatic move(input int side, input int loc, output int acc);
      int n = 0;
      while (((side == 1) ? c_ready : p_ready) !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 40) fail("ready_wait");
      acc = cyc;
      p_valid = 1'b1; c_valid = 1'b1;
      p_loc = (side == 0) ? 4'(loc) : 4'd8;
      c_loc = (side == 1) ? 4'(loc) : 4'd8;
      @(posedge clk); #1;
      p_valid = 1'b0; c_valid = 1'b0;
   endtask

   task automatic start_game(output int w);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_sig(2, "start_ready", w);
   endtask

   int acc, at, w;
   int pm [5] = '{0, 1, 2, 0, 0};
   int cm [5] = '{3, 5, 0, 0, 0};
   int dp [5] = '{0, 2, 3, 7, 8};
   int dc [5] = '{1, 4, 5, 6, 0};

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; tb_clr = 1'b0;
      chk("rst_game_over", game_over, 0);
      chk("rst_p_ready", p_ready, 0);
      chk("rst_move_cnt", move_cnt, 0);

      // start at cycle 0 -> board_clr at 1 only, player ready at 2
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("clr_at_1", board_clr, 1);
      chk("ready_at_1", p_ready, 0);
      @(posedge clk); #1;
      chk("clr_at_2", board_clr, 0);
      chk("p_ready_at_2", p_ready, 1);
      chk("c_ready_at_2", c_ready, 0);

      move(0, 4, acc);
      wait_sig(0, "we_wait", at);
      chk("we_latency", at - acc, 2);
      chk("we_loc", board_loc, 4);
      chk("we_val", board_val, 1);
      wait_sig(1, "c_ready_wait", at);
      chk("ready_latency", at - acc, 11);
      chk("turn_cpu", turn, 1);
      chk("cnt_1", move_cnt, 1);

      move(1, 0, acc);
      move(0, 4, acc);
      wait_sig(4, "err_occupied", at);
      chk("err_latency", at - acc, 2);
      chk("err_turn", turn, 0);
      move(0, 9, acc);
      wait_sig(4, "err_range", at);
      chk("err2_turn", turn, 0);
      chk("err_cnt", move_cnt, 2);

      // abort mid-game: no clear until the next start
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_clr", board_clr, 0);
         chk("abort_ready", p_ready, 0);
         @(posedge clk); #1;
      end

      // player wins on row 0; a stray start mid-game is ignored
      start_game(w);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         move(0, pm[i], acc);
         if (i < 2) move(1, cm[i], acc);
      end
      wait_sig(3, "win_wait", at);
      chk("win_latency", at - acc, 4);
      chk("win_winner", winner, 1);
      chk("win_cnt", move_cnt, 5);
      chk("win_p_ready", p_ready, 0);
      chk("win_c_ready", c_ready, 0);

      // draw over all nine cells
      start_game(w);
      for (int i = 0; i < 5; i++) begin
         move(0, dp[i], acc);
         if (i < 4) move(1, dc[i], acc);
      end
      wait_sig(3, "draw_wait", at);
      chk("draw_latency", at - acc, 11);
      chk("draw_winner", winner, 0);
      chk("draw_cnt", move_cnt, 9);

      start_game(w);
`ifdef GAME_CTRL_TIMEOUT_EN
      wait_sig(5, "timeout_wait", at);
      chk("timeout_latency", at - w, 16);
      chk("timeout_turn", turn, 1);
      chk("timeout_c_ready", c_ready, 1);
      chk("timeout_p_ready", p_ready, 0);
`else
      repeat (20) @(posedge clk);
      #1;
      chk("idle_p_ready", p_ready, 1);
      chk("idle_turn", turn, 0);
`endif
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
